id_ex_hazard_stage: RTL and testbench

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

---
 rtl/id_ex_hazard_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load followed by a dependent instruction gets one bubble, and upstream stages are held.
module id_ex_hazard_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Freeze,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [8:0]        ID_Ctrl,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [8:0]        EX_Ctrl,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              Stall,
    output logic [15:0]       StallCount
);

    localparam int unsigned CtrlMemRead = 6;

    typedef enum logic [0:0] {StRun, StBubble} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [8:0]        ctrl_q, ctrl_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              hazard;

    // Conservative: Rt is compared even when the ID instruction does not read it.
    assign hazard = ctrl_q[CtrlMemRead] && (rt_q != 5'd0) &&
                    ((rt_q == ID_Rs) || (rt_q == ID_Rt));

    always_comb begin
        state_d     = state_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        stall_cnt_d = stall_cnt_q;

        if (!Freeze) begin
            if (state_q == StRun && hazard) begin
                state_d = StBubble;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                rs_d    = '0;
                rt_d    = '0;
                rd_d    = '0;
                ctrl_d  = '0;
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else begin
                // Normal advance, or release of the instruction held during the bubble.
                state_d = StRun;
                rd1_d   = ID_ReadData1;
                rd2_d   = ID_ReadData2;
                imm_d   = ID_Imm;
                rs_d    = ID_Rs;
                rt_d    = ID_Rt;
                rd_d    = ID_Rd;
                ctrl_d  = ID_Ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        PCWrite     = !(Freeze || (state_q == StRun && hazard));
        IF_ID_Write = PCWrite;
        Stall       = (state_q == StBubble);
    end

    assign EX_ReadData1 = rd1_q;
    assign EX_ReadData2 = rd2_q;
    assign EX_Imm       = imm_q;
    assign EX_Rs        = rs_q;
    assign EX_Rt        = rt_q;
    assign EX_Rd        = rd_q;
    assign EX_Ctrl      = ctrl_q;
    assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: reset, pass-through, load-use bubble,
// zero register, freeze priority, counter saturation and reset mid-bubble.
module tb_id_ex_hazard_stage;

    localparam int unsigned DW = 32;
    localparam logic [8:0] CtrlLw  = 9'h1C0;
    localparam logic [8:0] CtrlAlu = 9'h100;

    logic          clk = 1'b0;
    logic          rst;
    logic          Freeze;
    logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic [8:0]    ID_Ctrl;
    logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [4:0]    EX_Rs, EX_Rt, EX_Rd;
    logic [8:0]    EX_Ctrl;
    logic          PCWrite, IF_ID_Write, Stall;
    logic [15:0]   StallCount;

    int tests = 0;
    int fails = 0;

    id_ex_hazard_stage #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .Freeze(Freeze),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Ctrl(ID_Ctrl),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Ctrl(EX_Ctrl),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .Stall(Stall),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [8:0] ctrl, input logic [DW-1:0] rd1);
        ID_Rs        = rs;
        ID_Rt        = rt;
        ID_Rd        = rd;
        ID_Ctrl      = ctrl;
        ID_ReadData1 = rd1;
        ID_ReadData2 = rd1 ^ 32'hFFFF_0000;
        ID_Imm       = rd1 + 32'd1;
    endtask

    initial begin
        // Reset with a busy-looking ID stage
        rst    = 1'b0;
        Freeze = 1'b0;
        drive(5'd31, 5'd31, 5'd31, 9'h1FF, 32'hDEADBEEF);
        tick();
        check("rst_ex_ctrl", 32'(EX_Ctrl), 32'h0);
        check("rst_ex_rd1", EX_ReadData1, 32'h0);
        check("rst_ex_rt", 32'(EX_Rt), 32'h0);
        check("rst_stall", 32'(Stall), 32'h0);
        check("rst_cnt", 32'(StallCount), 32'h0);
        check("rst_pcwrite", 32'(PCWrite), 32'h1);
        check("rst_ifid", 32'(IF_ID_Write), 32'h1);

        // Pass-through
        rst = 1'b1;
        drive(5'd1, 5'd2, 5'd3, CtrlAlu, 32'h5);
        #1;
        check("pt_pcwrite_pre", 32'(PCWrite), 32'h1);
        tick();
        check("pt_ex_rs", 32'(EX_Rs), 32'h1);
        check("pt_ex_rt", 32'(EX_Rt), 32'h2);
        check("pt_ex_rd", 32'(EX_Rd), 32'h3);
        check("pt_ex_rd1", EX_ReadData1, 32'h5);
        check("pt_ex_rd2", EX_ReadData2, 32'hFFFF_0005);
        check("pt_ex_imm", EX_Imm, 32'h6);
        check("pt_ex_ctrl", 32'(EX_Ctrl), 32'h100);
        check("pt_pcwrite", 32'(PCWrite), 32'h1);

        // Load-use: lw r8 into EX, then consumer with Rs=8
        drive(5'd0, 5'd8, 5'd0, CtrlLw, 32'h40);
        tick();
        check("lu_ex_ctrl_lw", 32'(EX_Ctrl), 32'h1C0);
        drive(5'd8, 5'd9, 5'd10, CtrlAlu, 32'h11);
        #1;
        check("lu_pcwrite", 32'(PCWrite), 32'h0);
        check("lu_ifid", 32'(IF_ID_Write), 32'h0);
        check("lu_stall_pre", 32'(Stall), 32'h0);
        tick();
        check("lu_bubble_ctrl", 32'(EX_Ctrl), 32'h0);
        check("lu_bubble_rs", 32'(EX_Rs), 32'h0);
        check("lu_bubble_rd1", EX_ReadData1, 32'h0);
        check("lu_stall", 32'(Stall), 32'h1);
        check("lu_cnt", 32'(StallCount), 32'h1);
        check("lu_bubble_pcwrite", 32'(PCWrite), 32'h1);
        tick();
        check("lu_after_rs", 32'(EX_Rs), 32'h8);
        check("lu_after_rd1", EX_ReadData1, 32'h11);
        check("lu_after_ctrl", 32'(EX_Ctrl), 32'h100);
        check("lu_after_stall", 32'(Stall), 32'h0);
        check("lu_after_cnt", 32'(StallCount), 32'h1);

        // Load-use through Rt only
        drive(5'd0, 5'd12, 5'd0, CtrlLw, 32'h0);
        tick();
        drive(5'd3, 5'd12, 5'd4, CtrlAlu, 32'h33);
        #1;
        check("lurt_pcwrite", 32'(PCWrite), 32'h0);
        tick();
        check("lurt_stall", 32'(Stall), 32'h1);
        check("lurt_cnt", 32'(StallCount), 32'h2);
        tick();
        check("lurt_after_rt", 32'(EX_Rt), 32'hC);

        // Zero register is never a hazard
        drive(5'd3, 5'd0, 5'd0, CtrlLw, 32'h0);
        tick();
        drive(5'd0, 5'd0, 5'd7, CtrlAlu, 32'h77);
        #1;
        check("zr_pcwrite", 32'(PCWrite), 32'h1);
        tick();
        check("zr_stall", 32'(Stall), 32'h0);
        check("zr_cnt", 32'(StallCount), 32'h2);
        check("zr_ex_rd", 32'(EX_Rd), 32'h7);

        // Freeze holds everything even with a pending hazard
        drive(5'd1, 5'd5, 5'd0, CtrlLw, 32'h50);
        tick();
        drive(5'd5, 5'd6, 5'd2, CtrlAlu, 32'h22);
        Freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_ex_ctrl", 32'(EX_Ctrl), 32'h1C0);
            check("fz_ex_rt", 32'(EX_Rt), 32'h5);
            check("fz_ex_rd1", EX_ReadData1, 32'h50);
            check("fz_cnt", 32'(StallCount), 32'h2);
            check("fz_stall", 32'(Stall), 32'h0);
            check("fz_pcwrite", 32'(PCWrite), 32'h0);
        end
        Freeze = 1'b0;
        #1;
        check("fz_rel_pcwrite", 32'(PCWrite), 32'h0);
        tick();
        check("fz_rel_stall", 32'(Stall), 32'h1);
        check("fz_rel_ctrl", 32'(EX_Ctrl), 32'h0);
        check("fz_rel_cnt", 32'(StallCount), 32'h3);
        tick();
        check("fz_after_rs", 32'(EX_Rs), 32'h5);
        check("fz_after_rd1", EX_ReadData1, 32'h22);

        // Saturation: preload the counter while frozen
        Freeze = 1'b1;
        force dut.stall_cnt_q = 16'hFFFF;
        tick();
        release dut.stall_cnt_q;
        tick();
        check("sat_preload", 32'(StallCount), 32'hFFFF);
        Freeze = 1'b0;
        drive(5'd0, 5'd6, 5'd0, CtrlLw, 32'h0);
        tick();
        drive(5'd6, 5'd1, 5'd1, CtrlAlu, 32'h66);
        tick();
        check("sat_stall", 32'(Stall), 32'h1);
        check("sat_cnt", 32'(StallCount), 32'hFFFF);

        // Reset mid-bubble, with Freeze also asserted
        rst    = 1'b0;
        Freeze = 1'b1;
        tick();
        check("rb_stall", 32'(Stall), 32'h0);
        check("rb_cnt", 32'(StallCount), 32'h0);
        check("rb_ex_ctrl", 32'(EX_Ctrl), 32'h0);
        check("rb_pcwrite_frozen", 32'(PCWrite), 32'h0);
        Freeze = 1'b0;
        #1;
        check("rb_pcwrite", 32'(PCWrite), 32'h1);
        rst = 1'b1;
        tick();
        check("rb_resume_rs", 32'(EX_Rs), 32'h6);
        check("rb_resume_stall", 32'(Stall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
